// File: rtl/bitnet_seq_pkg.sv
// Shared types and constants for the layer-wavefront sequencer.
package bitnet_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INIT     = 3'd1,
      S_FWD      = 3'd2,
      S_WAIT_ERR = 3'd3,
      S_BWD      = 3'd4
   } seq_state_t;

   // Feedback taps 16,14,13,11 for a left-shifting Fibonacci register.
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; free-runs every cycle, synchronous load of the seed.
module lfsr16
   import bitnet_seq_pkg::*;
(
   input  logic        clk_in,
   input  logic        load_in,
   input  logic [15:0] seed_in,
   output logic [15:0] state_out
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_ff @(posedge clk_in) begin
      if (load_in) begin
         lfsr_q <= seed_in;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_out = lfsr_q;

endmodule

// File: rtl/prop_sequencer.sv
// Layer-wavefront sequencer: forward strobes front-to-back, optional error
// handshake, backward strobes back-to-front, plus network reset and osc seeds.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for init or a pass request
//   INIT     | net_rst_out held for INIT_CYCLES cycles
//   FWD      | fd_prop strobe walking up; tail_q marks the result/done cycle
//   WAIT_ERR | result reported, waiting for the external error vector
//   BWD      | bk_prop strobe walking down; tail_q marks the done cycle
module prop_sequencer
   import bitnet_seq_pkg::*;
#(
   parameter int          N_LAYERS    = 4,
   parameter int          INIT_CYCLES = 2,
   parameter logic [15:0] SEED        = DEFAULT_SEED
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                init_in,
   input  logic                req_valid_in,
   input  logic                req_train_in,
   output logic                req_ready_out,
   input  logic                err_valid_in,
   output logic                err_ready_out,
   output logic [N_LAYERS-1:0] fd_prop_out,
   output logic [N_LAYERS-1:0] bk_prop_out,
   output logic                net_rst_out,
   output logic [N_LAYERS-1:0] osc_out,
   output logic                result_valid_out,
   output logic                done_out,
   output logic                busy_out
);

   localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
   localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_LAYERS - 1);
   localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(INIT_CYCLES - 1);
   localparam logic [N_LAYERS-1:0] STROBE_ONE = N_LAYERS'(1);

   seq_state_t          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tail_q, tail_d;
   logic                train_q, train_d;
   logic [N_LAYERS-1:0] fd_q, fd_d;
   logic [N_LAYERS-1:0] bk_q, bk_d;
   logic                rv_q, rv_d;
   logic                done_q, done_d;
   logic                err_rdy_q, err_rdy_d;
   logic                net_rst_q, net_rst_d;
   logic                busy_q, busy_d;
   logic                fd_en, bk_en;
   logic [15:0]         lfsr_w;
   logic                unused_lfsr_hi;

   lfsr16 u_lfsr (
      .clk_in    (clk_in),
      .load_in   (rst_in),
      .seed_in   (SEED),
      .state_out (lfsr_w)
   );

   assign unused_lfsr_hi = ^lfsr_w;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      tail_d    = tail_q;
      train_d   = train_q;
      fd_en     = 1'b0;
      bk_en     = 1'b0;
      rv_d      = 1'b0;
      done_d    = 1'b0;
      err_rdy_d = 1'b0;
      net_rst_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (init_in) begin
               state_d   = S_INIT;
               cnt_d     = CNT_LOAD;
               net_rst_d = 1'b1;
            end else if (req_valid_in) begin
               state_d = S_FWD;
               idx_d   = '0;
               tail_d  = 1'b0;
               train_d = req_train_in;
               fd_en   = 1'b1;
            end
         end
         S_INIT: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d     = cnt_q - CNT_W'(1);
               net_rst_d = 1'b1;
            end
         end
         S_FWD: begin
            if (tail_q) begin
               state_d = S_IDLE;
               tail_d  = 1'b0;
            end else if (idx_q == IDX_LAST) begin
               rv_d = 1'b1;
               if (train_q) begin
                  state_d   = S_WAIT_ERR;
                  err_rdy_d = 1'b1;
               end else begin
                  done_d = 1'b1;
                  tail_d = 1'b1;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
               fd_en = 1'b1;
            end
         end
         S_WAIT_ERR: begin
            if (err_valid_in) begin
               state_d = S_BWD;
               idx_d   = IDX_LAST;
               tail_d  = 1'b0;
               bk_en   = 1'b1;
            end else begin
               err_rdy_d = 1'b1;
            end
         end
         S_BWD: begin
            if (tail_q) begin
               state_d = S_IDLE;
               tail_d  = 1'b0;
            end else if (idx_q == '0) begin
               done_d = 1'b1;
               tail_d = 1'b1;
            end else begin
               idx_d = idx_q - IDX_W'(1);
               bk_en = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tail_d  = 1'b0;
         end
      endcase

      fd_d   = fd_en ? (STROBE_ONE << idx_d) : '0;
      bk_d   = bk_en ? (STROBE_ONE << idx_d) : '0;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         tail_q    <= 1'b0;
         train_q   <= 1'b0;
         fd_q      <= '0;
         bk_q      <= '0;
         rv_q      <= 1'b0;
         done_q    <= 1'b0;
         err_rdy_q <= 1'b0;
         net_rst_q <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         tail_q    <= tail_d;
         train_q   <= train_d;
         fd_q      <= fd_d;
         bk_q      <= bk_d;
         rv_q      <= rv_d;
         done_q    <= done_d;
         err_rdy_q <= err_rdy_d;
         net_rst_q <= net_rst_d;
         busy_q    <= busy_d;
      end
   end

   // Only the handshake-ready is combinational so init wins in its own cycle.
   assign req_ready_out    = (state_q == S_IDLE) && !init_in;
   assign err_ready_out    = err_rdy_q;
   assign fd_prop_out      = fd_q;
   assign bk_prop_out      = bk_q;
   assign net_rst_out      = net_rst_q;
   assign osc_out          = lfsr_w[N_LAYERS-1:0];
   assign result_valid_out = rv_q;
   assign done_out         = done_q;
   assign busy_out         = busy_q;

endmodule

// File: tb/tb_prop_sequencer.sv
// Directed bench for prop_sequencer (N_LAYERS=4, INIT_CYCLES=2, SEED=ACE1).
module tb_prop_sequencer;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       init_in = 1'b0;
   logic       req_valid_in = 1'b0;
   logic       req_train_in = 1'b0;
   logic       err_valid_in = 1'b0;
   logic       req_ready_out;
   logic       err_ready_out;
   logic [3:0] fd_prop_out;
   logic [3:0] bk_prop_out;
   logic       net_rst_out;
   logic [3:0] osc_out;
   logic       result_valid_out;
   logic       done_out;
   logic       busy_out;

   int          checks = 0;
   int          errors = 0;
   int          strobe_viol = 0;
   logic [15:0] m_lfsr = 16'h0;

   always #5 clk_in = ~clk_in;

   prop_sequencer #(.N_LAYERS(4), .INIT_CYCLES(2), .SEED(SEED)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .init_in          (init_in),
      .req_valid_in     (req_valid_in),
      .req_train_in     (req_train_in),
      .req_ready_out    (req_ready_out),
      .err_valid_in     (err_valid_in),
      .err_ready_out    (err_ready_out),
      .fd_prop_out      (fd_prop_out),
      .bk_prop_out      (bk_prop_out),
      .net_rst_out      (net_rst_out),
      .osc_out          (osc_out),
      .result_valid_out (result_valid_out),
      .done_out         (done_out),
      .busy_out         (busy_out)
   );

   typedef struct {
      logic       init;
      logic       req;
      logic       train;
      logic       err;
      logic [3:0] fd;
      logic [3:0] bk;
      logic       rv;
      logic       done;
      logic       erdy;
      logic       nrst;
      logic       busy;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic i, logic r, logic t, logic e, logic [3:0] f,
                               logic [3:0] b, logic rv, logic dn, logic er,
                               logic nr, logic bz, logic rd);
      vec_t v;
      v = '{i, r, t, e, f, b, rv, dn, er, nr, bz, rd};
      return v;
   endfunction

   function automatic logic [15:0] lfsr_step(logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic tick();
      @(posedge clk_in);
      if (rst_in) m_lfsr = SEED;
      else        m_lfsr = lfsr_step(m_lfsr);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if ((fd_prop_out != 4'b0 && bk_prop_out != 4'b0) ||
          $countones(fd_prop_out) > 1 || $countones(bk_prop_out) > 1)
         strobe_viol++;
   end

   initial begin
      int first;

      // forward-only pass
      vecs.push_back(mk(0,1,0,0, 4'h0,4'h0, 0,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0, 4'h1,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h2,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h4,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h8,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 1,1,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,0,0,0,0,1));
      // training pass, error withheld for a while
      vecs.push_back(mk(0,1,1,0, 4'h0,4'h0, 0,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0, 4'h1,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h2,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h4,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h8,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 1,0,1,0,1,0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,0,1,0,1,0));
      vecs.push_back(mk(0,0,0,1, 4'h0,4'h0, 0,0,1,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h8, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h4, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h2, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h1, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,1,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,0,0,0,0,1));
      // training pass, error accepted in the result cycle
      vecs.push_back(mk(0,1,1,0, 4'h0,4'h0, 0,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0, 4'h1,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h2,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h4,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h8,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,1, 4'h0,4'h0, 1,0,1,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h8, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h4, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h2, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h1, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,1,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,0,0,0,0,1));
      // init beats request; init/request outside IDLE ignored
      vecs.push_back(mk(1,1,0,0, 4'h0,4'h0, 0,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0, 4'h0,4'h0, 0,0,0,1,1,0));
      vecs.push_back(mk(0,1,0,0, 4'h0,4'h0, 0,0,0,1,1,0));
      vecs.push_back(mk(0,1,0,0, 4'h0,4'h0, 0,0,0,0,0,1));
      vecs.push_back(mk(1,1,0,0, 4'h1,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h2,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h4,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h8,4'h0, 0,0,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 1,1,0,0,1,0));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,0,0,0,0,1));
      vecs.push_back(mk(0,0,0,0, 4'h0,4'h0, 0,0,0,0,0,1));

      // reset state
      rst_in = 1'b1;
      repeat (3) tick();
      chk("rst_fd",    fd_prop_out, 4'h0);
      chk("rst_bk",    bk_prop_out, 4'h0);
      chk("rst_rv",    result_valid_out, 1'b0);
      chk("rst_done",  done_out, 1'b0);
      chk("rst_erdy",  err_ready_out, 1'b0);
      chk("rst_busy",  busy_out, 1'b0);
      chk("rst_nrst",  net_rst_out, 1'b1);
      chk("rst_osc",   osc_out, 4'h1);
      rst_in = 1'b0;
      #1;
      chk("rel_rdy",   req_ready_out, 1'b1);
      tick();
      chk("rel_nrst",  net_rst_out, 1'b0);

      // table-driven vectors
      for (int r = 0; r < vecs.size(); r++) begin
         init_in      = vecs[r].init;
         req_valid_in = vecs[r].req;
         req_train_in = vecs[r].train;
         err_valid_in = vecs[r].err;
         #1;
         chk($sformatf("row%0d_fd",   r), fd_prop_out,      vecs[r].fd);
         chk($sformatf("row%0d_bk",   r), bk_prop_out,      vecs[r].bk);
         chk($sformatf("row%0d_rv",   r), result_valid_out, vecs[r].rv);
         chk($sformatf("row%0d_done", r), done_out,         vecs[r].done);
         chk($sformatf("row%0d_erdy", r), err_ready_out,    vecs[r].erdy);
         chk($sformatf("row%0d_nrst", r), net_rst_out,      vecs[r].nrst);
         chk($sformatf("row%0d_busy", r), busy_out,         vecs[r].busy);
         chk($sformatf("row%0d_rdy",  r), req_ready_out,    vecs[r].rdy);
         chk($sformatf("row%0d_osc",  r), osc_out,          m_lfsr[3:0]);
         tick();
      end
      init_in = 1'b0; req_valid_in = 1'b0; req_train_in = 1'b0; err_valid_in = 1'b0;

      // reset in the middle of a forward pass
      req_valid_in = 1'b1;
      tick();
      req_valid_in = 1'b0;
      chk("abort_fd0", fd_prop_out, 4'h1);
      tick();
      chk("abort_fd1", fd_prop_out, 4'h2);
      rst_in = 1'b1;
      tick();
      chk("abort_fd",   fd_prop_out, 4'h0);
      chk("abort_bk",   bk_prop_out, 4'h0);
      chk("abort_nrst", net_rst_out, 1'b1);
      chk("abort_busy", busy_out, 1'b0);
      rst_in = 1'b0;
      #1;
      chk("abort_osc",  osc_out, 4'h1);
      chk("abort_rdy",  req_ready_out, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("abort_quiet%0d_done", i), done_out, 1'b0);
         chk($sformatf("abort_quiet%0d_fd", i), fd_prop_out, 4'h0);
         chk($sformatf("abort_quiet%0d_nrst", i), net_rst_out, 1'b0);
         chk($sformatf("abort_quiet%0d_busy", i), busy_out, 1'b0);
      end

      // LFSR period from the seed
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      first = 0;
      for (int i = 1; i <= 70000; i++) begin
         tick();
         if (dut.lfsr_w == SEED) begin
            first = i;
            break;
         end
      end
      chk("lfsr_period", first, 65535);
      chk("lfsr_osc_end", osc_out, m_lfsr[3:0]);
      chk("strobe_exclusive", strobe_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prop_sequencer.md
# prop_sequencer

Layer-wavefront sequencer for a stack of perceptron-unit layers. Accepts inference/training requests over a valid/ready handshake. Steps the per-layer `fd_prop` strobes front-to-back, reports the result, then optionally takes an error handshake and steps the `bk_prop` strobes back-to-front. It also drives the network reset and the pseudo-random oscillator bits that seed each unit's initial control weight.

## Interface
- `N_LAYERS`, default 4: number of unit layers sequenced; legal range 1..16.
- `INIT_CYCLES`, default 2: cycles `net_rst_out` is held for an init request; must be ≥1.
- `SEED`, default 16'hACE1: LFSR load value; must be nonzero.
- `clk_in` input 1: the single clock.
- `rst_in` input 1: synchronous, active-high reset.
- `init_in` input 1: re-randomise network weights; sampled only in IDLE.
- `req_valid_in` input 1: pass request valid.
- `req_train_in` input 1: 1 = forward+backward, 0 = forward only; qualified by `req_valid_in`.
- `req_ready_out` output 1: `(state==IDLE) && !init_in`.
- `err_valid_in` input 1: external error vector on `bin` lines is valid.
- `err_ready_out` output 1: high in WAIT_ERR.
- `fd_prop_out` output N_LAYERS: one-hot forward strobe, bit k drives layer k.
- `bk_prop_out` output N_LAYERS: one-hot backward strobe, bit k drives layer k.
- `net_rst_out` output 1: reset to all units.
- `osc_out` output N_LAYERS: `lfsr[N_LAYERS-1:0]`, bit k to layer k oscillator.
- `result_valid_out` output 1: one-cycle pulse; last layer `fout` is valid.
- `done_out` output 1: one-cycle pulse; pass complete.
- `busy_out` output 1: `state != IDLE`.

## Operation
- States: IDLE, INIT, FWD, WAIT_ERR, BWD. Layer counter `idx` has width `$clog2(N_LAYERS)`, minimum 1.
- IDLE:
  - `init_in` → INIT. `init_in` has priority over a request in the same cycle; `req_ready_out` is low that cycle.
  - Otherwise a request handshake → FWD with `idx`=0. `req_train_in` is latched into `train_q`.
- INIT: `net_rst_out`=1 for exactly INIT_CYCLES cycles, then IDLE.
- FWD: `fd_prop_out = 1<<idx`, and `idx` increments each cycle. After bit N_LAYERS-1:
  - `result_valid_out` pulses.
  - If `train_q`=0, `done_out` pulses in the same cycle and the state returns to IDLE.
  - Otherwise the state goes to WAIT_ERR.
- WAIT_ERR: holds indefinitely until `err_valid_in` is high. Then → BWD with `idx`=N_LAYERS-1.
- BWD: `bk_prop_out = 1<<idx`, and `idx` decrements. After bit 0, `done_out` pulses and the state returns to IDLE.
- Strobes are never both nonzero. Each strobe output has at most one bit set.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts every cycle, in all states including INIT. `rst_in` loads SEED.
- `N_LAYERS`=1: FWD and BWD each last one cycle.

## Timing
- All outputs are registered except `req_ready_out`, which is combinational on `init_in`.
- Reset values:
  - `fd_prop_out`=0, `bk_prop_out`=0.
  - `result_valid_out`=0, `done_out`=0, `err_ready_out`=0, `busy_out`=0.
  - `net_rst_out`=1 while `rst_in` is high; it drops the cycle after `rst_in` deasserts.
  - `osc_out`=SEED bits; state=IDLE.
- Request accepted at edge t:
  - `fd_prop_out[k]` is high in cycle t+1+k.
  - `result_valid_out` is high in cycle t+N_LAYERS+1.
  - Forward-only: `done_out` is high in cycle t+N_LAYERS+1, and `req_ready_out` returns in cycle t+N_LAYERS+2.
- Training: `err_ready_out` rises in cycle t+N_LAYERS+1, the same cycle as `result_valid_out`. An error accepted in that cycle is legal.
- Error accepted at edge e:
  - `bk_prop_out[N_LAYERS-1-k]` is high in cycle e+1+k.
  - `done_out` is high in cycle e+N_LAYERS+1.
  - IDLE is reached in cycle e+N_LAYERS+2.
- Init accepted at edge t: `net_rst_out` is high in cycles t+1..t+INIT_CYCLES. IDLE is reached in cycle t+INIT_CYCLES+1.
- `rst_in` mid-pass (any state) aborts on the next edge: all strobes go to 0, there is no `done_out`, and the state goes to IDLE.
- `init_in` or `req_valid_in` outside IDLE is ignored; it is not queued.

## Structure
- Package `bitnet_seq_pkg`: state enum `seq_state_t`, LFSR tap mask constant `LFSR_TAPS`, and default `SEED`.
- Sub-module `lfsr16` (clock, synchronous load of seed, 16-bit state out). The sequencer FSM and counters live in `prop_sequencer`.

## Test plan
- Reset, then N_LAYERS=4 forward-only request at edge 10 → `fd_prop_out` goes 0001, 0010, 0100, 1000 in cycles 11–14. `result_valid_out` and `done_out` are high in cycle 15. `req_ready_out` is high in cycle 16.
- Training request at edge 10, `err_valid_in` held low 5 extra cycles, then high → `bk_prop_out` goes 1000, 0100, 0010, 0001 on the four cycles after acceptance. `done_out` is high the next cycle. `fd_prop_out` and `bk_prop_out` are never both nonzero.
- `init_in` and `req_valid_in` both high in IDLE → `req_ready_out`=0 that cycle. `net_rst_out` is high for 2 cycles. No `fd_prop_out` strobe occurs until the request is re-accepted after returning to IDLE.
- `rst_in` asserted during `fd_prop_out`=0010 → the next cycle has all strobes 0 and `net_rst_out`=1. After release: IDLE, `osc_out`=SEED[3:0]=4'h1, and no `done_out`.
- Error accepted in the same cycle as `result_valid_out` → `bk_prop_out`=1000 in the following cycle.
- Free-run 65535 cycles after reset → `lfsr16` state returns to SEED exactly at cycle 65535 and not before.
